// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader that writes 18-bit words into
// program memory, then releases the CPU.
// Ports: i_clock, i_reset_n (async, active-low), i_start, i_byte[0:7],
//   i_valid / o_ready byte handshake, o_wAddr[0:15], o_wData[0:17], o_wEn,
//   o_busy, o_err, o_cpuRun.
// Build option: define PROG_LOADER_CHECKSUM_EN to add a trailing
//   checksum byte; the load then fails unless the 8-bit sum of all word
//   bytes plus the checksum byte is zero.
module prog_loader #(
   parameter int MAX_WORDS = 65535
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic [0:7]  i_byte,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [0:15] o_wAddr,
   output logic [0:17] o_wData,
   output logic        o_wEn,
   output logic        o_busy,
   output logic        o_err,
   output logic        o_cpuRun
);

   typedef enum logic [3:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      B0,
      B1,
      B2,
      WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM,
`endif
      DONE,
      ERR
   } stateT;

   localparam logic [0:15] maxWords = 16'(MAX_WORDS);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam stateT finState = CSUM;
`else
   localparam stateT finState = DONE;
`endif

   stateT       state;
   stateT       nextState;
   logic [0:15] wordCnt;
   logic [0:15] addr;
   logic [0:17] word;
   logic [0:15] lenFull;
   logic        lastWord;

   // Full count is only meaningful while the low byte is on i_byte.
   assign lenFull  = {wordCnt[0:7], i_byte};
   assign lastWord = (addr + 16'd1) == wordCnt;
   assign o_wAddr  = addr;
   assign o_wData  = word;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [0:7] sum;
   logic [0:7] sumTotal;
   assign sumTotal = sum + i_byte;
`endif

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      o_ready   = 1'b0;
      o_wEn     = 1'b0;
      o_busy    = 1'b1;
      o_err     = 1'b0;
      o_cpuRun  = 1'b0;
      unique case (state)
         IDLE: begin
            o_busy = 1'b0;
            if (i_start) nextState = LEN_HI;
         end
         LEN_HI: begin
            o_ready = 1'b1;
            if (i_valid) nextState = LEN_LO;
         end
         LEN_LO: begin
            o_ready = 1'b1;
            if (i_valid) begin
               if (lenFull > maxWords) nextState = ERR;
               else if (lenFull == '0) nextState = finState;
               else nextState = B0;
            end
         end
         B0: begin
            o_ready = 1'b1;
            if (i_valid) nextState = B1;
         end
         B1: begin
            o_ready = 1'b1;
            if (i_valid) nextState = B2;
         end
         B2: begin
            o_ready = 1'b1;
            if (i_valid) nextState = WRITE;
         end
         WRITE: begin
            o_wEn     = 1'b1;
            nextState = lastWord ? finState : B0;
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CSUM: begin
            o_ready = 1'b1;
            if (i_valid) nextState = (sumTotal == '0) ? DONE : ERR;
         end
`endif
         DONE: begin
            o_busy   = 1'b0;
            o_cpuRun = 1'b1;
            if (i_start) nextState = LEN_HI;
         end
         ERR: begin
            o_busy = 1'b0;
            o_err  = 1'b1;
            if (i_start) nextState = LEN_HI;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wordCnt <= '0;
         addr    <= '0;
         word    <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: if (i_start) addr <= '0;
            LEN_HI: if (i_valid) wordCnt[0:7] <= i_byte;
            LEN_LO: if (i_valid) wordCnt[8:15] <= i_byte;
            // Upper six bits of the first byte are padding.
            B0: if (i_valid) word[0:1] <= i_byte[6:7];
            B1: if (i_valid) word[2:9] <= i_byte;
            B2: if (i_valid) word[10:17] <= i_byte;
            WRITE: addr <= addr + 16'd1;
            default: ;
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sum <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERR: if (i_start) sum <= '0;
            B0, B1, B2: if (i_valid) sum <= sumTotal;
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; a full-size instance
// and a MAX_WORDS=4 instance share one byte driver selected by sel.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [0:7]  byteIn = '0;
   logic        valid = 1'b0;
   logic        sel = 1'b0;

   logic        ready, wEn, busy, err, cpuRun;
   logic [0:15] wAddr;
   logic [0:17] wData;
   logic        sReady, sWEn, sBusy, sErr, sCpuRun;
   logic [0:15] sWAddr;
   logic [0:17] sWData;
   logic        curReady;

   int checks = 0;
   int errors = 0;
   int wrCount = 0;
   logic [7:0] tbSum;

   typedef struct packed {
      logic [15:0] a;
      logic [17:0] d;
   } wrT;
   wrT expQ[$];

   assign curReady = sel ? sReady : ready;

   always #5 clk = ~clk;

   prog_loader dut (
      .i_clock(clk), .i_reset_n(rstN),
      .i_start(start & ~sel), .i_byte(byteIn),
      .i_valid(valid & ~sel), .o_ready(ready),
      .o_wAddr(wAddr), .o_wData(wData), .o_wEn(wEn),
      .o_busy(busy), .o_err(err), .o_cpuRun(cpuRun)
   );

   prog_loader #(.MAX_WORDS(4)) dutSmall (
      .i_clock(clk), .i_reset_n(rstN),
      .i_start(start & sel), .i_byte(byteIn),
      .i_valid(valid & sel), .o_ready(sReady),
      .o_wAddr(sWAddr), .o_wData(sWData), .o_wEn(sWEn),
      .o_busy(sBusy), .o_err(sErr), .o_cpuRun(sCpuRun)
   );

   always @(negedge clk) begin
      if (wEn === 1'b1) begin
         wrT e;
         wrCount++;
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected addr=%h data=%h", wAddr, wData);
         end else begin
            e = expQ.pop_front();
            if (wAddr !== e.a || wData !== e.d) begin
               errors++;
               $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                        wAddr, wData, e.a, e.d);
            end
         end
      end
      if (sWEn === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL small_write got wEn=1 want 0 addr=%h", sWAddr);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int stall);
      int n;
      repeat ($urandom_range(0, stall)) begin
         valid = 1'b0;
         byteIn = 8'($urandom);
         tick();
      end
      byteIn = b;
      valid = 1'b1;
      n = 0;
      while (curReady !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (curReady !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got ready=%b want 1", curReady);
      end
      tick();
      valid = 1'b0;
   endtask

   task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int a,
                           input int stall);
      wrT e;
      int v;
      v = (int'(b0) % 4) * 65536 + int'(b1) * 256 + int'(b2);
      e.a = 16'(a);
      e.d = 18'(v);
      expQ.push_back(e);
      tbSum = 8'(tbSum + b0 + b1 + b2);
      sendByte(b0, stall);
      sendByte(b1, stall);
      sendByte(b2, stall);
   endtask

   task automatic waitEnd();
      int n = 0;
      while (cpuRun !== 1'b1 && err !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({ready, wEn, busy, err, cpuRun, wAddr, wData} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b%b%b%b%b %h %h want all 0",
                  ready, wEn, busy, err, cpuRun, wAddr, wData);
      end
      checks++;
      if ({sReady, sWEn, sBusy, sErr, sCpuRun} !== 5'b0) begin
         errors++;
         $display("FAIL reset_small got %b%b%b%b%b want 0",
                  sReady, sWEn, sBusy, sErr, sCpuRun);
      end
      tick();
      rstN = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL idle got busy=%b ready=%b want 0 0", busy, ready);
      end
   endtask

   task automatic test_basic();
      int w0 = wrCount;
      tbSum = '0;
      pulseStart();
      checks++;
      if (busy !== 1'b1 || ready !== 1'b1) begin
         errors++;
         $display("FAIL len_hi got busy=%b ready=%b want 1 1", busy, ready);
      end
      sendByte(8'h00, 0);
      sendByte(8'h02, 0);
      sendWord(8'hFF, 8'h12, 8'h34, 0, 0);
      sendWord(8'h01, 8'hAB, 8'hCD, 1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      sendByte(8'(8'd0 - tbSum), 0);
`endif
      waitEnd();
      checks++;
      if (cpuRun !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done got run=%b err=%b busy=%b want 1 0 0",
                  cpuRun, err, busy);
      end
      checks++;
      if (wrCount - w0 != 2 || expQ.size() != 0) begin
         errors++;
         $display("FAIL basic_writes got %0d left %0d want 2 left 0",
                  wrCount - w0, expQ.size());
      end
   endtask

   task automatic test_zero();
      int w0 = wrCount;
      pulseStart();
      checks++;
      if (cpuRun !== 1'b0) begin
         errors++;
         $display("FAIL restart_run got %b want 0", cpuRun);
      end
      sendByte(8'h00, 0);
      sendByte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
      checks++;
      if (ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_csum got ready=%b busy=%b want 1 1", ready, busy);
      end
      sendByte(8'h00, 0);
`endif
      checks++;
      if (cpuRun !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done got run=%b busy=%b want 1 0", cpuRun, busy);
      end
      checks++;
      if (wrCount != w0) begin
         errors++;
         $display("FAIL zero_writes got %0d want 0", wrCount - w0);
      end
   endtask

   task automatic test_back_to_back();
      int w0 = wrCount;
      tbSum = '0;
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h03, 0);
      for (int i = 0; i < 3; i++) begin
         sendWord(8'($urandom), 8'($urandom), 8'($urandom), i, 0);
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      sendByte(8'(8'd0 - tbSum), 0);
`endif
      waitEnd();
      checks++;
      if (cpuRun !== 1'b1 || wrCount - w0 != 3 || expQ.size() != 0) begin
         errors++;
         $display("FAIL b2b got run=%b writes=%0d left=%0d want 1 3 0",
                  cpuRun, wrCount - w0, expQ.size());
      end
   endtask

`ifdef PROG_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h01, 0);
      sendWord(8'h02, 8'h00, 8'h01, 0, 0);
      sendByte(8'hFD, 0);
      checks++;
      if (cpuRun !== 1'b1 || err !== 1'b0) begin
         errors++;
         $display("FAIL csum_good got run=%b err=%b want 1 0", cpuRun, err);
      end
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h01, 0);
      sendWord(8'h02, 8'h00, 8'h01, 0, 0);
      sendByte(8'hFE, 0);
      checks++;
      if (cpuRun !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL csum_bad got run=%b err=%b want 0 1", cpuRun, err);
      end
   endtask
`endif

   task automatic test_max_words();
      sel = 1'b1;
      pulseStart();
      sendByte(8'h00, 0);
      sendByte(8'h05, 0);
      checks++;
      if (sErr !== 1'b1 || sCpuRun !== 1'b0 || sBusy !== 1'b0) begin
         errors++;
         $display("FAIL max_over got err=%b run=%b busy=%b want 1 0 0",
                  sErr, sCpuRun, sBusy);
      end
      pulseStart();
      checks++;
      if (sErr !== 1'b0) begin
         errors++;
         $display("FAIL err_clear got %b want 0", sErr);
      end
      sendByte(8'h00, 0);
      sendByte(8'h04, 0);
      checks++;
      if (sErr !== 1'b0 || sBusy !== 1'b1 || sReady !== 1'b1) begin
         errors++;
         $display("FAIL max_equal got err=%b busy=%b ready=%b want 0 1 1",
                  sErr, sBusy, sReady);
      end
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      sel = 1'b0;
      tick();
   endtask

   task automatic test_stall_reset();
      int w0 = wrCount;
      pulseStart();
      sendByte(8'h00, 3);
      sendByte(8'h05, 3);
      for (int i = 0; i < 3; i++) begin
         sendWord(8'($urandom), 8'($urandom), 8'($urandom), i, 3);
      end
      sendByte(8'h03, 3);
      sendByte(8'h77, 3);
      #2;
      rstN = 1'b0;
      #1;
      checks++;
      if ({ready, wEn, busy, err, cpuRun, wAddr, wData} !== '0) begin
         errors++;
         $display("FAIL abort_outputs got %b%b%b%b%b %h %h want all 0",
                  ready, wEn, busy, err, cpuRun, wAddr, wData);
      end
      valid = 1'b1;
      byteIn = 8'h55;
      repeat (4) tick();
      valid = 1'b0;
      rstN = 1'b1;
      repeat (3) tick();
      checks++;
      if (wrCount - w0 != 3 || expQ.size() != 0) begin
         errors++;
         $display("FAIL abort_writes got %0d left %0d want 3 left 0",
                  wrCount - w0, expQ.size());
      end
      checks++;
      if (busy !== 1'b0 || cpuRun !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b run=%b want 0 0", busy, cpuRun);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_max_words();
      test_stall_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 65535, meaning the largest word count accepted (range 1..65535).
REQ-002 SHALL have port i_clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset_n  input  1  meaning reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  meaning a one-cycle request to begin a load.
REQ-005 SHALL have port i_byte  input  [0:7]  meaning the incoming byte, bit 0 MSB.
REQ-006 SHALL have port i_valid  input  1  meaning i_byte is valid.
REQ-007 SHALL have port o_ready  output  1  meaning the loader can accept a byte this cycle.
REQ-008 SHALL have port o_wAddr  output  [0:15]  meaning the program-memory write address.
REQ-009 SHALL have port o_wData  output  [0:17]  meaning the 18-bit instruction word, bit 0 MSB.
REQ-010 SHALL have port o_wEn  output  1  meaning the program-memory write strobe.
REQ-011 SHALL have port o_busy  output  1  meaning a load is in progress.
REQ-012 SHALL have port o_err  output  1  meaning the last load failed.
REQ-013 SHALL have port o_cpuRun  output  1  meaning the CPU may fetch; CPU held while 0.

Function
REQ-014 SHALL accept a byte only on a cycle where i_valid=1 and o_ready=1.
REQ-015 SHALL use states IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CSUM, DONE, ERR.
REQ-016 SHALL drive o_ready=1 only in LEN_HI, LEN_LO, B0, B1, B2 and CSUM.
REQ-017 SHALL move from IDLE, DONE or ERR to LEN_HI on i_start=1, clearing o_cpuRun, o_err and the address counter.
REQ-018 SHALL ignore i_start in every other state.
REQ-019 SHALL take word count N big-endian: byte 1 is N[0:7] (LEN_HI), byte 2 is N[8:15] (LEN_LO).
REQ-020 SHALL go to ERR after LEN_LO when N>MAX_WORDS.
REQ-021 SHALL go to CSUM (macro on) or DONE (macro off) after LEN_LO when N=0, issuing no writes.
REQ-022 SHALL assemble each word from three bytes: B0 bits [6:7] give word [0:1] (bits [0:5] ignored), B1 gives [2:9], B2 gives [10:17].
REQ-023 SHALL, after B2 is accepted, spend exactly one cycle in WRITE with o_wEn=1, o_wData=assembled word and o_wAddr=current address.
REQ-024 SHALL start addresses at 0 and increment by 1 after each write; address k holds word k; no wrap occurs because N<=65535.
REQ-025 SHALL go from WRITE to B0 while words remain, otherwise to CSUM (macro on) or DONE (macro off).
REQ-026 SHALL drive o_wEn=0 in every state other than WRITE.
REQ-027 SHALL hold o_busy=1 in every state except IDLE, DONE and ERR.
REQ-028 SHALL set o_cpuRun=1 in DONE only; o_err=1 in ERR only.
REQ-029 SHALL hold state and assembled data unchanged while i_valid=0 (stall of any length).

Reset
REQ-030 SHALL, while i_reset_n=0 and independently of i_clock, force state IDLE and o_ready=0, o_wEn=0, o_busy=0, o_err=0, o_cpuRun=0, o_wAddr=0 and o_wData=0.
REQ-031 SHALL, on reset asserted mid-load, abandon the load with no further writes; words already written are not erased.

Configuration
REQ-032 SHALL, with PROG_LOADER_CHECKSUM_EN defined, sum all B0/B1/B2 bytes modulo 256, and go from CSUM to DONE when (sum + checksum byte) mod 256 = 0, otherwise to ERR.
REQ-033 SHALL, without PROG_LOADER_CHECKSUM_EN, omit the CSUM state and its sum register and go to DONE directly after the last WRITE.

Verification
REQ-034 SHALL cover: start, then bytes 00 02, FF 12 34, 01 AB CD (macro off) -> writes addr0=18'h31234 and addr1=18'h1ABCD, then o_cpuRun=1.
REQ-035 SHALL cover: macro on, bytes 00 01 02 00 01, then checksum FD -> one write at addr0=18'h20001, then DONE; checksum FE instead -> o_err=1, o_cpuRun=0.
REQ-036 SHALL cover: MAX_WORDS=4, bytes 00 05 -> ERR with no o_wEn pulse.
REQ-037 SHALL cover: N=0 (macro off) -> DONE two accepted bytes after start, no writes.
REQ-038 SHALL cover: i_valid toggled randomly, and i_reset_n pulled low after B1 of word 3 -> identical write data despite the stalls, no write for word 3, all outputs 0 immediately.
